// File: rtl/btn_event_arb.sv
// Button event arbiter: turns debounced button levels into press/release/long-press
// events and serialises them round-robin onto one valid/ready stream.
// Optional long-press detection is enabled by defining BTN_EVT_LONGPRESS_EN.
module btn_event_arb #(
  parameter int IDW         = 2,
  parameter int LONG_PERIOD = 10_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [(1<<IDW)-1:0]  i_btn,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [IDW-1:0]       o_evt_id,
  output logic [1:0]           o_evt_type,
  output logic                 o_drop
);

  localparam int NBTN = 1 << IDW;

  localparam logic [1:0] EVT_PRESS = 2'b00;
  localparam logic [1:0] EVT_REL   = 2'b01;
  localparam logic [1:0] EVT_LONG  = 2'b10;

  if (LONG_PERIOD < 2 || LONG_PERIOD >= (1 << 24)) begin : g_bad_long_period
    $error("btn_event_arb: LONG_PERIOD must be in [2, 2^24)");
  end

  // Handshake: an event transfers on a posedge with o_valid & i_ready; while
  // o_valid & ~i_ready the id/type are held and o_valid stays high.

  logic [NBTN-1:0] r_prev;
  logic [NBTN-1:0] r_p_press;
  logic [NBTN-1:0] r_p_rel;
  logic [IDW-1:0]  r_rr;
  logic            r_valid;
  logic [IDW-1:0]  r_id;
  logic [1:0]      r_type;
  logic            r_drop;

  logic [NBTN-1:0] w_rise;
  logic [NBTN-1:0] w_fall;
  logic [NBTN-1:0] w_p_long;
  logic [NBTN-1:0] w_elig;
  logic            w_slot_free;
  logic            w_found;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_gnt_id;
  logic [1:0]      w_gnt_type;
  logic            w_grant;
  logic [NBTN-1:0] w_gnt_oh;
  logic [NBTN-1:0] w_clr_press;
  logic [NBTN-1:0] w_clr_rel;
  logic [NBTN-1:0] w_drop_long;
  logic [NBTN-1:0] w_drop_vec;

  assign w_rise      = i_btn & ~r_prev;
  assign w_fall      = ~i_btn & r_prev;
  assign w_elig      = r_p_press | r_p_rel | w_p_long;
  assign w_slot_free = ~r_valid | i_ready;

  // Round-robin search starting at r_rr; index arithmetic wraps modulo NBTN.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int i = 0; i < NBTN; i++) begin
      w_idx = r_rr + IDW'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  // Press before long before release keeps per-channel event order intact.
  always_comb begin
    w_gnt_type = EVT_REL;
    if (r_p_press[w_gnt_id]) begin
      w_gnt_type = EVT_PRESS;
    end else if (w_p_long[w_gnt_id]) begin
      w_gnt_type = EVT_LONG;
    end
  end

  assign w_grant     = w_slot_free & w_found;
  assign w_gnt_oh    = w_grant ? (NBTN'(1) << w_gnt_id) : '0;
  assign w_clr_press = w_gnt_oh & {NBTN{w_gnt_type == EVT_PRESS}};
  assign w_clr_rel   = w_gnt_oh & {NBTN{w_gnt_type == EVT_REL}};

`ifdef BTN_EVT_LONGPRESS_EN
  localparam logic [23:0] LP_M1 = 24'(LONG_PERIOD - 1);
  localparam logic [23:0] LP_M2 = 24'(LONG_PERIOD - 2);

  logic [23:0]     r_hold [NBTN];
  logic [NBTN-1:0] r_p_long;
  logic [NBTN-1:0] w_set_long;
  logic [NBTN-1:0] w_clr_long;

  always_comb begin
    w_set_long = '0;
    for (int c = 0; c < NBTN; c++) begin
      w_set_long[c] = r_prev[c] && (r_hold[c] == LP_M2);
    end
  end

  assign w_clr_long  = w_gnt_oh & {NBTN{w_gnt_type == EVT_LONG}};
  assign w_p_long    = r_p_long;
  assign w_drop_long = w_set_long & r_p_long & ~w_clr_long;

  // Saturating hold counter: the LONG_PERIOD-2 -> LONG_PERIOD-1 step happens once per hold.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p_long <= '0;
      for (int c = 0; c < NBTN; c++) begin
        r_hold[c] <= '0;
      end
    end else begin
      r_p_long <= w_set_long | (r_p_long & ~w_clr_long);
      for (int c = 0; c < NBTN; c++) begin
        if (!r_prev[c]) begin
          r_hold[c] <= '0;
        end else if (r_hold[c] != LP_M1) begin
          r_hold[c] <= r_hold[c] + 24'd1;
        end
      end
    end
  end
`else
  assign w_p_long    = '0;
  assign w_drop_long = '0;
`endif

  // A set onto a flag that is being cleared this cycle is a new event, not a loss.
  assign w_drop_vec = (w_rise & r_p_press & ~w_clr_press)
                    | (w_fall & r_p_rel & ~w_clr_rel)
                    | w_drop_long;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev    <= '0;
      r_p_press <= '0;
      r_p_rel   <= '0;
      r_rr      <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_type    <= EVT_PRESS;
      r_drop    <= 1'b0;
    end else begin
      r_prev    <= i_btn;
      r_p_press <= w_rise | (r_p_press & ~w_clr_press);
      r_p_rel   <= w_fall | (r_p_rel & ~w_clr_rel);
      r_drop    <= |w_drop_vec;
      if (w_grant) begin
        r_valid <= 1'b1;
        r_id    <= w_gnt_id;
        r_type  <= w_gnt_type;
        r_rr    <= w_gnt_id + IDW'(1);
      end else if (w_slot_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_evt_id   = r_id;
  assign o_evt_type = r_type;
  assign o_drop     = r_drop;

endmodule
